// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter for cpu fetch and data ports
module mem_port_arbiter #(
  parameter int DATA_WIDTH        = 36,
  parameter int INSTRUCTION_WIDTH = 18,
  parameter int ADDRESS_BUS_WIDTH = 14,
  parameter int MAX_DATA_BURST    = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,

  // instruction-fetch requester
  input  logic                         i_if_req,
  input  logic [ADDRESS_BUS_WIDTH-1:0] i_if_addr,
  output logic                         o_if_gnt,
  output logic                         o_if_rvalid,
  output logic [INSTRUCTION_WIDTH-1:0] o_if_instr,

  // data load/store requester
  input  logic                         i_dm_req,
  input  logic                         i_dm_we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0]        i_dm_wdata,
  output logic                         o_dm_gnt,
  output logic                         o_dm_rvalid,
  output logic [DATA_WIDTH-1:0]        o_dm_rdata,

  // shared memory port
  output logic [ADDRESS_BUS_WIDTH-1:0] o_mem_addr,
  output logic                         o_mem_write,
  output logic                         o_mem_read,
  output logic [DATA_WIDTH-1:0]        o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]        i_mem_rdata
);

  // Four bits covers the whole legal burst range of 1..15.
  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  // Consecutive data grants issued while a fetch has been waiting.
  logic [3:0] burst_cnt;

  // Tags recording which requester owns the read landing next cycle.
  logic pend_if;
  logic pend_dm;

  logic if_gnt;
  logic dm_gnt;

  // Grant decision: data wins unless the waiting fetch has used up its patience.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!i_rst) begin
      if (i_dm_req && i_if_req) begin
        if (burst_cnt == BURST_MAX) begin
          if_gnt = 1'b1;
        end else begin
          dm_gnt = 1'b1;
        end
      end else if (i_dm_req) begin
        dm_gnt = 1'b1;
      end else if (i_if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Steer the winning requester onto the memory port.
  always_comb begin
    o_mem_addr  = i_dm_addr;
    o_mem_wdata = i_dm_wdata;
    o_mem_write = 1'b0;
    o_mem_read  = 1'b0;
    if (if_gnt) begin
      o_mem_addr = i_if_addr;
      o_mem_read = 1'b1;
    end else if (dm_gnt) begin
      o_mem_write = i_dm_we;
      o_mem_read  = !i_dm_we;
    end
  end

  // Starvation counter: counts data grants only while a fetch is waiting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      burst_cnt <= 4'd0;
    end else if (if_gnt || !i_if_req) begin
      burst_cnt <= 4'd0;
    end else if (dm_gnt && (burst_cnt != BURST_MAX)) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  // Response tags: writes complete at grant, so only reads are tagged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_if <= 1'b0;
      pend_dm <= 1'b0;
    end else begin
      pend_if <= if_gnt;
      pend_dm <= dm_gnt && !i_dm_we;
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_dm_gnt    = dm_gnt;
  assign o_if_rvalid = pend_if;
  assign o_dm_rvalid = pend_dm;
  assign o_if_instr  = i_mem_rdata[INSTRUCTION_WIDTH-1:0];
  assign o_dm_rdata  = i_mem_rdata;

`ifndef SYNTHESIS
  // Only one requester may own the port, and it is either a read or a write.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      a_one_grant: assert (!(if_gnt && dm_gnt))
        else $error("arbiter issued two grants in one cycle");
      a_one_op: assert (!(o_mem_read && o_mem_write))
        else $error("memory read and write driven together");
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int DW = 36;
  localparam int IW = 18;
  localparam int AW = 14;
  localparam int MB = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [IW-1:0] o_if_instr;
  logic          i_dm_req;
  logic          i_dm_we;
  logic [AW-1:0] i_dm_addr;
  logic [DW-1:0] i_dm_wdata;
  logic          o_dm_gnt;
  logic          o_dm_rvalid;
  logic [DW-1:0] o_dm_rdata;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_write;
  logic          o_mem_read;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          cap_we;
  logic          cap_re;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [11:0]   exp_if_pat;
  logic [4:0]    exp_short_pat;

  localparam logic [DW-1:0] WORD = 36'hABCDE1234;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .INSTRUCTION_WIDTH(IW),
    .ADDRESS_BUS_WIDTH(AW), .MAX_DATA_BURST(MB)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_instr(o_if_instr),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid),
    .o_dm_rdata(o_dm_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_write(o_mem_write), .o_mem_read(o_mem_read),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // memory request is captured mid-cycle so the model never races the DUT edge
  always @(negedge i_clk) begin
    #3;
    cap_we    = o_mem_write;
    cap_re    = o_mem_read;
    cap_addr  = o_mem_addr;
    cap_wdata = o_mem_wdata;
  end

  // 1-cycle synchronous memory model
  always @(posedge i_clk) begin
    if (cap_we) mem[cap_addr] <= cap_wdata;
    if (cap_re) i_mem_rdata <= mem[cap_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic ifr, input logic [AW-1:0] ifa, input logic dmr,
                     input logic we, input logic [AW-1:0] dma, input logic [DW-1:0] wd);
    i_if_req   = ifr;
    i_if_addr  = ifa;
    i_dm_req   = dmr;
    i_dm_we    = we;
    i_dm_addr  = dma;
    i_dm_wdata = wd;
  endtask

  task automatic next_cycle();
    @(negedge i_clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 1);
    i_mem_rdata = '0;
    cap_we = 1'b0; cap_re = 1'b0; cap_addr = '0; cap_wdata = '0;
    exp_if_pat    = 12'b0010_0001_0000;
    exp_short_pat = 5'b10000;

    // reset with both requests pending: everything must stay quiet
    i_rst = 1'b1;
    drv(1'b1, 14'h0, 1'b1, 1'b0, 14'h0, '0);
    next_cycle(); #1;
    chk("rst_if_gnt", 64'(o_if_gnt), 64'd0);
    chk("rst_dm_gnt", 64'(o_dm_gnt), 64'd0);
    chk("rst_mem_rd", 64'(o_mem_read), 64'd0);
    chk("rst_mem_wr", 64'(o_mem_write), 64'd0);
    chk("rst_if_rv", 64'(o_if_rvalid), 64'd0);
    chk("rst_dm_rv", 64'(o_dm_rvalid), 64'd0);
    next_cycle();
    i_rst = 1'b0;
    drv(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, '0);

    // fetch-only stream, addresses 0..3
    for (int a = 0; a < 4; a++) begin
      next_cycle();
      drv(1'b1, AW'(a), 1'b0, 1'b0, 14'h0, '0);
      #1;
      chk("fetch_gnt", 64'(o_if_gnt), 64'd1);
      chk("fetch_nodm", 64'(o_dm_gnt), 64'd0);
      chk("fetch_rd", 64'(o_mem_read), 64'd1);
      chk("fetch_addr", 64'(o_mem_addr), 64'(a));
      chk("fetch_rv", 64'(o_if_rvalid), (a == 0) ? 64'd0 : 64'd1);
      if (a > 0) chk("fetch_instr", 64'(o_if_instr), 64'(a));
    end
    next_cycle();
    drv(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, '0);
    #1;
    chk("fetch_idle_gnt", 64'(o_if_gnt), 64'd0);
    chk("fetch_last_rv", 64'(o_if_rvalid), 64'd1);
    chk("fetch_last_instr", 64'(o_if_instr), 64'h4);

    // data write then read back
    next_cycle();
    drv(1'b0, 14'h0, 1'b1, 1'b1, 14'h100, WORD);
    #1;
    chk("wr_gnt", 64'(o_dm_gnt), 64'd1);
    chk("wr_we", 64'(o_mem_write), 64'd1);
    chk("wr_re", 64'(o_mem_read), 64'd0);
    chk("wr_addr", 64'(o_mem_addr), 64'h100);
    chk("wr_wdata", 64'(o_mem_wdata), 64'(WORD));
    next_cycle();
    drv(1'b0, 14'h0, 1'b1, 1'b0, 14'h100, '0);
    #1;
    chk("rd_gnt", 64'(o_dm_gnt), 64'd1);
    chk("rd_re", 64'(o_mem_read), 64'd1);
    chk("wr_no_rv", 64'(o_dm_rvalid), 64'd0);
    next_cycle();
    drv(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, '0);
    #1;
    chk("rd_rv", 64'(o_dm_rvalid), 64'd1);
    chk("rd_data", 64'(o_dm_rdata), 64'(WORD));

    // contention for 12 cycles: DM x4 then IF, repeating
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      drv(1'b1, 14'h0, 1'b1, 1'b0, 14'h100, '0);
      #1;
      chk("burst_if", 64'(o_if_gnt), 64'(exp_if_pat[i]));
      chk("burst_dm", 64'(o_dm_gnt), 64'(!exp_if_pat[i]));
      chk("burst_excl", 64'(o_if_gnt && o_dm_gnt), 64'd0);
      if (i == 5 || i == 10) begin
        chk("burst_if_rv", 64'(o_if_rvalid), 64'd1);
        chk("burst_if_instr", 64'(o_if_instr), 64'h1);
      end
    end
    next_cycle();
    drv(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, '0);

    // fetch in N, data read in N+1: responses routed separately
    next_cycle();
    drv(1'b1, 14'h2, 1'b0, 1'b0, 14'h0, '0);
    #1;
    chk("mix_if_gnt", 64'(o_if_gnt), 64'd1);
    next_cycle();
    drv(1'b0, 14'h0, 1'b1, 1'b0, 14'h100, '0);
    #1;
    chk("mix_dm_gnt", 64'(o_dm_gnt), 64'd1);
    chk("mix_if_rv", 64'(o_if_rvalid), 64'd1);
    chk("mix_dm_rv0", 64'(o_dm_rvalid), 64'd0);
    chk("mix_instr", 64'(o_if_instr), 64'h3);
    next_cycle();
    drv(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, '0);
    #1;
    chk("mix_if_rv0", 64'(o_if_rvalid), 64'd0);
    chk("mix_dm_rv", 64'(o_dm_rvalid), 64'd1);
    chk("mix_dm_data", 64'(o_dm_rdata), 64'(WORD));

    // reset right after a data read grant; counter is left at 1 beforehand
    next_cycle();
    drv(1'b1, 14'h0, 1'b1, 1'b0, 14'h100, '0);
    #1;
    chk("prerst_dm_gnt", 64'(o_dm_gnt), 64'd1);
    next_cycle();
    i_rst = 1'b1;
    #1;
    chk("midrst_dm_rv", 64'(o_dm_rvalid), 64'd0);
    chk("midrst_dm_gnt", 64'(o_dm_gnt), 64'd0);
    chk("midrst_if_gnt", 64'(o_if_gnt), 64'd0);
    chk("midrst_mem_rd", 64'(o_mem_read), 64'd0);
    next_cycle();
    i_rst = 1'b0;
    // counter must restart from 0: DM x4 then IF
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      #1;
      chk("postrst_if", 64'(o_if_gnt), 64'(exp_short_pat[i]));
      chk("postrst_dm", 64'(o_dm_gnt), 64'(!exp_short_pat[i]));
      chk("postrst_dm_rv", 64'(o_dm_rvalid), (i == 0) ? 64'd0 : 64'd1);
      if (i > 0) chk("postrst_dm_data", 64'(o_dm_rdata), 64'(WORD));
    end

    // fetch to 0x5 abandoned while data keeps the port busy
    next_cycle();
    drv(1'b1, 14'h5, 1'b1, 1'b0, 14'h100, '0);
    #1;
    chk("drop_dm0", 64'(o_dm_gnt), 64'd1);
    next_cycle();
    #1;
    chk("drop_dm1", 64'(o_dm_gnt), 64'd1);
    next_cycle();
    drv(1'b0, 14'h5, 1'b1, 1'b0, 14'h100, '0);
    #1;
    chk("drop_no_if", 64'(o_if_gnt), 64'd0);
    chk("drop_addr", 64'(o_mem_addr), 64'h100);
    // fetch returns: a fresh count means four data grants before it wins
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drv(1'b1, 14'h5, 1'b1, 1'b0, 14'h100, '0);
      #1;
      chk("redo_if", 64'(o_if_gnt), 64'(exp_short_pat[i]));
      chk("redo_dm", 64'(o_dm_gnt), 64'(!exp_short_pat[i]));
    end
    next_cycle();
    drv(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, '0);
    #1;
    chk("redo_if_rv", 64'(o_if_rvalid), 64'd1);
    chk("redo_instr", 64'(o_if_instr), 64'h6);
    chk("redo_dm_rv", 64'(o_dm_rvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
